// File: rtl/dlx_pkg.sv
// Shared DLX definitions: instruction constants, opcodes and the fetch-stage state encoding.
package dlx_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0015;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQZ    = 6'h04;
    localparam logic [5:0] OP_BNEZ    = 6'h05;
    localparam logic [5:0] OP_ADDI    = 6'h08;
    localparam logic [5:0] OP_JR      = 6'h12;
    localparam logic [5:0] OP_JALR    = 6'h13;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2B;

    typedef enum logic [1:0] {
        FETCH = 2'b00,
        HOLD  = 2'b01,
        DRAIN = 2'b10
    } fetch_state_e;

    // Sequential PC step; wraps modulo 2^32.
    function automatic logic [31:0] pc_inc(input logic [31:0] addr);
        return addr + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_stage.sv
// DLX instruction fetch plus IF/ID register: owns the PC, runs the imem request handshake,
// and turns decode's branch redirect and load-use stall into bubbles or held instructions.
module fetch_stage
    import dlx_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter bit          DELAY_SLOT = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [0:31] imem_rdata,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        load_stall,
    output logic [0:31] id_instr,
    output logic [31:0] id_pc_plus_four,
    output logic        id_kill
);

    localparam logic [31:0] PC_INIT = {RESET_PC[31:2], 2'b00};

    fetch_state_e state, state_next;

    logic [31:0] pc;
    logic [31:0] req_addr;
    logic [0:31] hold_reg;
    logic [31:0] hold_pc;
    logic        redirect_pending;
    logic [31:0] redirect_target;

    logic [31:0] target_aligned;
    logic [31:0] seq_next;
    logic        unused_target_lsbs;

    assign target_aligned     = {branch_target[31:2], 2'b00};
    assign unused_target_lsbs = ^branch_target[1:0];

    // Address of the fetch following an acked, non-branch response.
    assign seq_next = redirect_pending ? redirect_target : pc_inc(req_addr);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) state <= FETCH;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            FETCH: begin
                if (branch_taken) begin
                    if (!DELAY_SLOT && !imem_ack) state_next = DRAIN;
                end else if (imem_ack && load_stall) begin
                    state_next = HOLD;
                end
            end
            HOLD:    state_next = FETCH;
            DRAIN:   if (imem_ack) state_next = FETCH;
            default: state_next = FETCH;
        endcase
    end

    always_comb begin
        imem_req  = !reset && (state != HOLD);
        imem_addr = req_addr;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc               <= PC_INIT;
            req_addr         <= PC_INIT;
            hold_reg         <= NOP_INSTR;
            hold_pc          <= PC_INIT;
            redirect_pending <= 1'b0;
            redirect_target  <= PC_INIT;
            id_instr         <= NOP_INSTR;
            id_pc_plus_four  <= PC_INIT;
            id_kill          <= 1'b1;
        end else begin
            // Bubble unless a branch below delivers; id_pc_plus_four holds its value.
            id_instr <= NOP_INSTR;
            id_kill  <= 1'b1;
            unique case (state)
                FETCH: begin
                    if (branch_taken) begin
                        if (DELAY_SLOT) begin
                            if (imem_ack) begin
                                id_instr         <= imem_rdata;
                                id_pc_plus_four  <= pc_inc(req_addr);
                                id_kill          <= 1'b0;
                                pc               <= target_aligned;
                                req_addr         <= target_aligned;
                                redirect_pending <= 1'b0;
                            end else begin
                                redirect_pending <= 1'b1;
                                redirect_target  <= target_aligned;
                            end
                        end else begin
                            // Wrong-path response is dropped; DRAIN keeps req up until it lands.
                            pc <= target_aligned;
                            if (imem_ack) req_addr <= target_aligned;
                        end
                    end else if (imem_ack) begin
                        pc               <= seq_next;
                        req_addr         <= seq_next;
                        redirect_pending <= 1'b0;
                        if (load_stall) begin
                            hold_reg <= imem_rdata;
                            hold_pc  <= req_addr;
                        end else begin
                            id_instr        <= imem_rdata;
                            id_pc_plus_four <= pc_inc(req_addr);
                            id_kill         <= 1'b0;
                        end
                    end
                end
                HOLD: begin
                    id_instr        <= hold_reg;
                    id_pc_plus_four <= pc_inc(hold_pc);
                    id_kill         <= 1'b0;
                end
                DRAIN: begin
                    if (imem_ack) req_addr <= pc;
                end
                default: ;
            endcase
        end
    end

    // Decode can never stall on a load and redirect in the same cycle.
    assert property (@(posedge clk) disable iff (reset) !(branch_taken && load_stall));

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: per-cycle vector tables for both delay-slot variants
// plus hand-written reset sequences.
module tb_fetch_stage;

    typedef struct {
        logic        ack;
        logic [31:0] rdata;
        logic        stall;
        logic        br;
        logic [31:0] tgt;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic [31:0] exp_instr;
        logic [31:0] exp_pc4;
        logic        exp_kill;
    } vec_t;

    localparam logic [31:0] NOP = 32'h0000_0015;

    logic clk = 1'b0;
    logic reset;

    logic        req1, ack1, stall1, br1, kill1;
    logic [31:0] addr1, tgt1, pc4_1;
    logic [0:31] rdata1, instr1;

    logic        req0, ack0, stall0, br0, kill0;
    logic [31:0] addr0, tgt0, pc4_0;
    logic [0:31] rdata0, instr0;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(32'h0), .DELAY_SLOT(1'b1)) u_dut_ds1 (
        .clk(clk), .reset(reset),
        .imem_req(req1), .imem_addr(addr1), .imem_ack(ack1), .imem_rdata(rdata1),
        .branch_taken(br1), .branch_target(tgt1), .load_stall(stall1),
        .id_instr(instr1), .id_pc_plus_four(pc4_1), .id_kill(kill1)
    );

    fetch_stage #(.RESET_PC(32'h0), .DELAY_SLOT(1'b0)) u_dut_ds0 (
        .clk(clk), .reset(reset),
        .imem_req(req0), .imem_addr(addr0), .imem_ack(ack0), .imem_rdata(rdata0),
        .branch_taken(br0), .branch_target(tgt0), .load_stall(stall0),
        .id_instr(instr0), .id_pc_plus_four(pc4_0), .id_kill(kill0)
    );

    function automatic logic [31:0] ins(input logic [31:0] a);
        return 32'h2000_0000 | a;
    endfunction

    function automatic vec_t v(input logic ack, input logic [31:0] rdata, input logic stall,
                               input logic br, input logic [31:0] tgt, input logic ereq,
                               input logic [31:0] eaddr, input logic [31:0] einstr,
                               input logic [31:0] epc4, input logic ekill);
        vec_t r;
        r.ack = ack; r.rdata = rdata; r.stall = stall; r.br = br; r.tgt = tgt;
        r.exp_req = ereq; r.exp_addr = eaddr; r.exp_instr = einstr;
        r.exp_pc4 = epc4; r.exp_kill = ekill;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        ack1 = 1'b0; rdata1 = '0; stall1 = 1'b0; br1 = 1'b0; tgt1 = '0;
        ack0 = 1'b0; rdata0 = '0; stall0 = 1'b0; br0 = 1'b0; tgt0 = '0;
    endtask

    task automatic check_if_id(input string tag, input bit sel, input logic [31:0] einstr,
                               input logic [31:0] epc4, input logic ekill);
        if (sel) begin
            check({tag, " instr"}, instr1, einstr);
            check({tag, " pc4"}, pc4_1, epc4);
            check({tag, " kill"}, {31'd0, kill1}, {31'd0, ekill});
        end else begin
            check({tag, " instr"}, instr0, einstr);
            check({tag, " pc4"}, pc4_0, epc4);
            check({tag, " kill"}, {31'd0, kill0}, {31'd0, ekill});
        end
    endtask

    // One clock per vector: drive on the falling edge, check the request side before the
    // rising edge and the IF/ID register just after it.
    task automatic run(input vec_t t, input bit sel, input string tag);
        @(negedge clk);
        idle_inputs();
        if (sel) begin
            ack1 = t.ack; rdata1 = t.rdata; stall1 = t.stall; br1 = t.br; tgt1 = t.tgt;
        end else begin
            ack0 = t.ack; rdata0 = t.rdata; stall0 = t.stall; br0 = t.br; tgt0 = t.tgt;
        end
        #1;
        check({tag, " req"}, {31'd0, sel ? req1 : req0}, {31'd0, t.exp_req});
        if (t.exp_req) check({tag, " addr"}, sel ? addr1 : addr0, t.exp_addr);
        @(posedge clk);
        #1;
        check_if_id(tag, sel, t.exp_instr, t.exp_pc4, t.exp_kill);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        check("rst req ds1", {31'd0, req1}, 32'd0);
        check("rst req ds0", {31'd0, req0}, 32'd0);
        check_if_id("rst ds1", 1'b1, NOP, 32'h0, 1'b1);
        check_if_id("rst ds0", 1'b0, NOP, 32'h0, 1'b1);
        @(negedge clk);
        reset = 1'b0;
    endtask

    vec_t tbl1[$];
    vec_t tbl0[$];

    initial begin
        // DELAY_SLOT=1: straight line, slow imem, load-use, late delay slot, target masking, wrap.
        tbl1.push_back(v(1, ins(32'h00), 0, 0, 0, 1, 32'h00, ins(32'h00), 32'h04, 0));
        tbl1.push_back(v(1, ins(32'h04), 0, 0, 0, 1, 32'h04, ins(32'h04), 32'h08, 0));
        tbl1.push_back(v(1, ins(32'h08), 0, 0, 0, 1, 32'h08, ins(32'h08), 32'h0C, 0));
        tbl1.push_back(v(1, ins(32'h0C), 0, 0, 0, 1, 32'h0C, ins(32'h0C), 32'h10, 0));
        tbl1.push_back(v(0, 0,            0, 0, 0, 1, 32'h10, NOP,         32'h10, 1));
        tbl1.push_back(v(0, 0,            0, 0, 0, 1, 32'h10, NOP,         32'h10, 1));
        tbl1.push_back(v(1, ins(32'h10), 0, 0, 0, 1, 32'h10, ins(32'h10), 32'h14, 0));
        tbl1.push_back(v(1, ins(32'h14), 1, 0, 0, 1, 32'h14, NOP,         32'h14, 1));
        tbl1.push_back(v(0, 0,            0, 0, 0, 0, 32'h00, ins(32'h14), 32'h18, 0));
        tbl1.push_back(v(1, ins(32'h18), 0, 0, 0, 1, 32'h18, ins(32'h18), 32'h1C, 0));
        tbl1.push_back(v(1, ins(32'h1C), 0, 0, 0, 1, 32'h1C, ins(32'h1C), 32'h20, 0));
        tbl1.push_back(v(1, ins(32'h20), 0, 0, 0, 1, 32'h20, ins(32'h20), 32'h24, 0));
        tbl1.push_back(v(0, 0,            0, 1, 32'h100, 1, 32'h24, NOP,  32'h24, 1));
        tbl1.push_back(v(0, 0,            0, 0, 0, 1, 32'h24, NOP,         32'h24, 1));
        tbl1.push_back(v(1, ins(32'h24), 0, 0, 0, 1, 32'h24, ins(32'h24), 32'h28, 0));
        tbl1.push_back(v(1, ins(32'h100), 0, 0, 0, 1, 32'h100, ins(32'h100), 32'h104, 0));
        tbl1.push_back(v(1, ins(32'h104), 0, 1, 32'h203, 1, 32'h104, ins(32'h104), 32'h108, 0));
        tbl1.push_back(v(1, ins(32'h200), 0, 0, 0, 1, 32'h200, ins(32'h200), 32'h204, 0));
        tbl1.push_back(v(1, ins(32'h204), 0, 1, 32'hFFFF_FFFC, 1, 32'h204, ins(32'h204), 32'h208, 0));
        tbl1.push_back(v(1, ins(32'hFFFF_FFFC), 0, 0, 0, 1, 32'hFFFF_FFFC, ins(32'hFFFF_FFFC), 32'h0, 0));
        tbl1.push_back(v(1, ins(32'h00), 0, 0, 0, 1, 32'h00, ins(32'h00), 32'h04, 0));

        // DELAY_SLOT=0: same-cycle-ack squash, then late-ack redirect through DRAIN.
        tbl0.push_back(v(1, ins(32'h00), 0, 0, 0, 1, 32'h00, ins(32'h00), 32'h04, 0));
        tbl0.push_back(v(1, ins(32'h04), 0, 1, 32'h20, 1, 32'h04, NOP, 32'h04, 1));
        tbl0.push_back(v(1, ins(32'h20), 0, 0, 0, 1, 32'h20, ins(32'h20), 32'h24, 0));
        tbl0.push_back(v(0, 0,            0, 1, 32'h100, 1, 32'h24, NOP,  32'h24, 1));
        tbl0.push_back(v(0, 0,            0, 0, 0, 1, 32'h24, NOP,         32'h24, 1));
        tbl0.push_back(v(1, ins(32'h24), 0, 0, 0, 1, 32'h24, NOP,         32'h24, 1));
        tbl0.push_back(v(1, ins(32'h100), 0, 0, 0, 1, 32'h100, ins(32'h100), 32'h104, 0));

        reset = 1'b1;
        idle_inputs();
        do_reset();

        foreach (tbl1[i]) run(tbl1[i], 1'b1, $sformatf("ds1 v%0d", i));

        // Reset while a request is outstanding; the ack arriving during reset must be ignored.
        run(v(0, 0, 0, 0, 0, 1, 32'h04, NOP, 32'h04, 1), 1'b1, "mid req");
        @(negedge clk);
        reset  = 1'b1;
        ack1   = 1'b1;
        rdata1 = 32'hDEAD_BEEF;
        #1;
        check("mid rst req", {31'd0, req1}, 32'd0);
        @(posedge clk);
        #1;
        check_if_id("mid rst", 1'b1, NOP, 32'h0, 1'b1);
        @(negedge clk);
        reset = 1'b0;
        idle_inputs();
        #1;
        check("post rst req", {31'd0, req1}, 32'd1);
        check("post rst addr", addr1, 32'h0);
        @(posedge clk);
        #1;
        check_if_id("post rst", 1'b1, NOP, 32'h0, 1'b1);
        run(v(1, ins(32'h00), 0, 0, 0, 1, 32'h00, ins(32'h00), 32'h04, 0), 1'b1, "post rst v0");

        do_reset();
        foreach (tbl0[i]) run(tbl0[i], 1'b0, $sformatf("ds0 v%0d", i));

        @(negedge clk);
        idle_inputs();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
